// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: PS/2 lines, CPU pop request and status/data word
interface ps2_keyboard_if;
    logic        ps2c;
    logic        ps2d;
    logic        ack;
    logic [15:0] dout;
    modport master (output ps2c, ps2d, ack, input dout);
    modport slave  (input ps2c, ps2d, ack, output dout);
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 frame receiver feeding a scan-code FIFO read by the CPU
module ps2_keyboard #(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_keyboard_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nx;
    logic [1:0]      c_sync, d_sync;
    logic            c_filt, flip, fall, d, tmo, push;
    logic [FW-1:0]   f_cnt;
    logic [2:0]      cnt;
    logic [7:0]      shreg;
    logic            par;
    logic [TW-1:0]   tout;
    logic            ack_d, pop, do_pop, do_push, empty, full, ovf;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;

    assign d    = d_sync[1];
    assign flip = (c_sync[1] != c_filt) && (f_cnt == FW'(FILTER_LEN - 1));
    assign fall = flip && c_filt;
    assign tmo  = tout == TW'(TIMEOUT_CYCLES - 1);

    // synchronize both lines and debounce the clock line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            c_filt <= 1'b1;
            f_cnt  <= '0;
        end else begin
            c_sync <= {c_sync[0], bus.ps2c};
            d_sync <= {d_sync[0], bus.ps2d};
            if (c_sync[1] == c_filt || flip) f_cnt <= '0;
            else f_cnt <= f_cnt + 1'b1;
            if (flip) c_filt <= c_sync[1];
        end
    end

    // frame state, data shift register, parity latch and inactivity timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            tout  <= '0;
        end else begin
            state <= state_nx;
            tout  <= (state == IDLE || fall) ? '0 : tout + 1'b1;
            if (fall && state == IDLE) cnt <= '0;
            if (fall && state == DATA) begin
                shreg <= {d, shreg[7:1]};
                cnt   <= cnt + 1'b1;
            end
            if (fall && state == PARITY) par <= d;
        end
    end

    // next-state decode; a stop-bit fall with good parity and stop requests a push
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        if (state != IDLE && !fall && tmo) state_nx = IDLE;
        else if (fall) begin
            case (state)
                IDLE:   state_nx = d ? IDLE : DATA;
                DATA:   state_nx = (cnt == 3'd7) ? PARITY : DATA;
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    push     = d & (^{shreg, par});
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign pop     = bus.ack & ~ack_d;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // FIFO pointers, occupancy, sticky overflow and ack edge detector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            ack_d <= 1'b0;
        end else begin
            ack_d <= bus.ack;
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (do_pop) ovf <= 1'b0;
            else if (push && full) ovf <= 1'b1;
        end
    end

    // FIFO storage needs no reset since empty masks the head byte
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= shreg;
    end

    assign bus.dout = {~empty, ovf, 6'b0, empty ? 8'h00 : mem[rptr]};
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed PS/2 frame tests with hand-computed status words
module tb_ps2_keyboard;
    localparam int TO = 2000;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    ps2_keyboard_if bus();

    ps2_keyboard #(.FIFO_DEPTH(4), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dout=%h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        bus.ps2d = b;
        cyc(8);
        bus.ps2c = 1'b0;
        cyc(16);
        bus.ps2c = 1'b1;
        cyc(8);
    endtask

    task automatic send_range(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(f[i]);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_range(frame(b, ~^b, 1'b1), 0, 10);
    endtask

    task automatic ack_hold(input int n);
        bus.ack = 1'b1;
        cyc(n);
        bus.ack = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        bus.ack  = 1'b0;
        cyc(3);
        check("reset", bus.dout, 16'h0000);
        rst_n = 1'b1;
        cyc(20);

        send_ok(8'h1C);
        check("frame_1c", bus.dout, 16'h801C);
        bus.ack = 1'b1;
        cyc(1);
        check("ack_first_cycle", bus.dout, 16'h0000);
        cyc(9);
        bus.ack = 1'b0;
        cyc(1);
        check("ack_held", bus.dout, 16'h0000);

        send_range(frame(8'h1C, 1'b1, 1'b1), 0, 10);
        check("bad_parity", bus.dout, 16'h0000);
        send_range(frame(8'h1C, 1'b0, 1'b0), 0, 10);
        check("bad_stop", bus.dout, 16'h0000);
        send_ok(8'hF0);
        check("frame_f0", bus.dout, 16'h80F0);
        ack_hold(1);

        for (int i = 1; i <= 5; i++) send_ok(8'(i));
        check("overflow", bus.dout, 16'hC001);
        ack_hold(10);
        check("pop1", bus.dout, 16'h8002);
        ack_hold(10);
        check("pop2", bus.dout, 16'h8003);
        ack_hold(10);
        check("pop3", bus.dout, 16'h8004);
        ack_hold(10);
        check("pop4", bus.dout, 16'h0000);
        ack_hold(3);
        check("pop_empty", bus.dout, 16'h0000);

        send_range(frame(8'h29, 1'b0, 1'b1), 0, 4);
        cyc(TO + 10);
        check("timeout_partial", bus.dout, 16'h0000);
        send_ok(8'h29);
        check("after_timeout", bus.dout, 16'h8029);
        ack_hold(1);

        send_range(frame(8'h66, 1'b1, 1'b1), 0, 4);
        cyc(TO - 100);
        send_range(frame(8'h66, 1'b1, 1'b1), 5, 10);
        check("slow_frame", bus.dout, 16'h8066);
        ack_hold(1);

        bus.ps2d = 1'b0;
        bus.ps2c = 1'b0;
        cyc(2);
        bus.ps2c = 1'b1;
        cyc(20);
        send_ok(8'h5A);
        check("glitch", bus.dout, 16'h805A);
        ack_hold(1);

        send_ok(8'h1C);
        check("queued_1c", bus.dout, 16'h801C);
        send_range(frame(8'h1C, 1'b0, 1'b1), 0, 3);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("mid_reset", bus.dout, 16'h0000);
        send_range(frame(8'h1C, 1'b0, 1'b1), 4, 10);
        check("broken_tail", bus.dout, 16'h0000);
        cyc(TO + 10);
        send_ok(8'h33);
        check("after_reset", bus.dout, 16'h8033);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
